rr_arb_ctrl: RTL
================

RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_HOLD, default 8, maximum grant length in cycles (1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N  per-requester request level; bit i = requester i.
REQ-006 rel  input  1  release strobe from current owner; ignored when no grant is active.
REQ-007 gnt  output  N  registered one-hot grant, all-zero when idle.
REQ-008 owner  output  $clog2(N)  index of granted requester; 0 when gnt is zero.
REQ-009 busy  output  1  high while gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The FSM SHALL have states IDLE, HOLD and GAP; all outputs registered.
REQ-012 IDLE: req == 0 -> stay IDLE; else -> HOLD, gnt/owner/busy valid the next cycle (1-cycle latency).
REQ-013 Winner SHALL be the first set req bit searching from ptr upward, wrapping N-1 -> 0.
REQ-014 ptr SHALL update to (winner+1) mod N on every grant; ptr is not changed otherwise.
REQ-015 HOLD: gnt SHALL stay constant; hold counter counts cycles spent in HOLD, starting at 1.
REQ-016 HOLD exits to GAP on rel=1, or req[owner]=0, or (timeout feature) counter == MAX_HOLD.
REQ-017 Exit by rel or dropped req SHALL take priority over the hold limit in the same cycle; timeout not pulsed.
REQ-018 On exit to GAP: gnt = 0, owner = 0, busy = 0 on the following cycle.
REQ-019 GAP SHALL last exactly one cycle with no grant, then -> IDLE, unconditional.
REQ-020 Requests from other requesters during HOLD/GAP SHALL be held off and never lost (level-sensitive).
REQ-021 At most one gnt bit SHALL be set in any cycle; gnt[i] implies req[i] was set in the granting cycle.
REQ-022 Any requester with req held continuously SHALL be granted within N*(MAX_HOLD+2) cycles (timeout enabled).

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, gnt=0, owner=0, busy=0, timeout=0, ptr=0, counter=0.
REQ-024 rst asserted mid-HOLD SHALL drop the grant asynchronously; no timeout pulse is generated.
REQ-025 After rst deassertion, the first arbitration SHALL start from requester 0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: hold counter and limit active; revoke at counter == MAX_HOLD with timeout pulse in the GAP cycle.
REQ-027 ARB_TIMEOUT_EN undefined: no counter logic; a grant persists until rel or req[owner] drop; timeout tied to 0.

Verification
REQ-028 Reset, then req=4'b0101 at cycle 0 -> gnt=4'b0001, owner=0 at cycle 1; rel at cycle 3 -> gnt=0 at cycle 4 (GAP), gnt=4'b0100 at cycle 6.
REQ-029 req=4'b1111 held, rel pulsed each HOLD cycle 1 -> grant order 0,1,2,3,0; each grant separated by one GAP cycle plus one IDLE cycle.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=8, req=4'b0010 held, no rel -> gnt=4'b0010 for exactly 8 cycles, timeout=1 for one cycle, regrant to 1 after the GAP and IDLE cycles.
REQ-031 rel=1 on the same cycle the counter reaches MAX_HOLD -> grant released, timeout stays 0.
REQ-032 rst pulsed mid-HOLD with owner=2 -> gnt=0 asynchronously; after release, req=4'b1100 -> owner=2 (ptr back to 0).
REQ-033 Formal: assert $onehot0(gnt), busy == |gnt, gnt[i] -> req[i] held or in grant cycle, no grant in GAP, bounded-wait per REQ-022.

Source files
------------

// File: rtl/rr_arb_if.sv
// Handshake bundle between requesters and the round-robin arbiter.
// The master side drives requests and release; the slave side returns the grant.
interface rr_arb_if #(
   parameter int N = 4
);
   localparam int OW = $clog2(N);

   logic [N-1:0]  req;
   logic          rel;
   logic [N-1:0]  gnt;
   logic [OW-1:0] owner;
   logic          busy;
   logic          timeout;

   modport master (
      output req,
      output rel,
      input  gnt,
      input  owner,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  rel,
      output gnt,
      output owner,
      output busy,
      output timeout
   );
endinterface

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter with IDLE/HOLD/GAP grant sequencing and registered outputs.
// Define ARB_TIMEOUT_EN to enable the hold counter that revokes grants after MAX_HOLD cycles.
module rr_arb_ctrl #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic      clk,
   input  logic      rst,
   rr_arb_if.slave   arb
);

   localparam int OW = $clog2(N);
   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam bit CFG_OK = (N >= 2) && (N <= 8) && (MAX_HOLD >= 1) && (MAX_HOLD <= 255);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] ptr_q, ptr_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;

   logic          win_valid;
   logic [OW-1:0] win_idx;
   logic [OW-1:0] win_next;
   logic [N-1:0]  win_onehot;
   logic          owner_req;

   // Scan from ptr upward with wrap; the lowest offset that hits wins,
   // so iterate from the far end and let closer hits overwrite.
   always_comb begin
      int            idx;
      logic [OW-1:0] cand;
      win_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      cand      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         cand = OW'(idx);
         if (arb.req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      int nxt;
      nxt = int'(win_idx) + 1;
      if (nxt >= N) begin
         nxt = 0;
      end
      win_next = OW'(nxt);
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign win_onehot[gi] = (win_idx == OW'(gi));
      end
   endgenerate

   assign owner_req = arb.req[owner_q];

`ifdef ARB_TIMEOUT_EN
   logic [CW-1:0] cnt_q, cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      busy_d    = busy_q;
      ptr_d     = ptr_q;
      timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = HOLD;
               gnt_d   = win_onehot;
               owner_d = win_idx;
               busy_d  = 1'b1;
               ptr_d   = win_next;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = CW'(1);
`endif
            end
         end
         HOLD: begin
            // Voluntary release or a dropped request outranks the hold limit.
            if (arb.rel || !owner_req) begin
               state_d = GAP;
               gnt_d   = '0;
               owner_d = '0;
               busy_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_q == CW'(MAX_HOLD)) begin
               state_d   = GAP;
               gnt_d     = '0;
               owner_d   = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
`endif
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign arb.gnt     = gnt_q;
   assign arb.owner   = owner_q;
   assign arb.busy    = busy_q;
   assign arb.timeout = timeout_q;

   // Structural invariants of the grant outputs.
   a_cfg_ok:    assert property (@(posedge clk) CFG_OK);
   a_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
   a_busy:      assert property (@(posedge clk) disable iff (rst) busy_q == (|gnt_q));
   a_gap_empty: assert property (@(posedge clk) disable iff (rst) (state_q == GAP) |-> (gnt_q == '0));
   a_idle_zero: assert property (@(posedge clk) disable iff (rst) (gnt_q == '0) |-> (owner_q == '0));

endmodule
